// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the down_timer block.
//               - state_t : control state encoding (2 bits)
//               - c_default_width : default counter width
// Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    localparam int c_default_width = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/down_count_core.sv
`default_nettype none
// ============================================================================
// Module      : down_count_core
// Description : WIDTH-bit count register with clear, load and decrement
//               controls, plus a combinational "count equals one" flag.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset, clears the count
//   i_clr      : synchronous clear (highest priority)
//   i_load     : load i_load_val
//   i_load_val : value to load
//   i_dec      : decrement by one (lowest priority)
//   o_count    : registered count
//   o_is_one   : high when o_count == 1
// Revision    : 1.0  initial release
// ============================================================================
module down_count_core
    import timer_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_is_one
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            // Zero guard keeps the count from ever wrapping.
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_is_one = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
// Module      : down_timer
// Description : Loadable one-shot countdown timer. A start in IDLE captures
//               i_len, the count decrements on each enabled clock, and
//               expiry is signalled by a one-cycle registered o_done pulse.
//               Optional macro DOWN_TIMER_AUTO_RELOAD_EN turns the timer
//               periodic: on expiry the count reloads from the captured
//               length and the timer stays in RUN until aborted or reset.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_start : start request, sampled only in IDLE
//   i_len   : countdown length, captured with an accepted start
//   i_en    : count enable
//   i_abort : cancel a running countdown (priority over i_en)
//   o_busy  : high while in RUN
//   o_done  : one-cycle expiry pulse, registered
//   o_count : current remaining count, registered
// Revision    : 1.0  initial release
// ============================================================================
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_len,
    input  logic             i_en,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_done;
    logic             w_done_evt;
    logic             w_clr;
    logic             w_load;
    logic             w_dec;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_count;
    logic             w_is_one;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_len;

    // Length is only needed to restart the countdown on each expiry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len <= '0;
        end else if ((r_state == ST_IDLE) && i_start && (i_len != '0)) begin
            r_len <= i_len;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_evt;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_load_val   = i_len;
        w_done_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_load       = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        // Zero length expires at once; count is already 0.
                        w_state_next = ST_DONE;
                        w_done_evt   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_clr        = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (i_en) begin
                    if (w_is_one) begin
                        w_done_evt = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        w_load       = 1'b1;
                        w_load_val   = r_len;
`else
                        w_clr        = 1'b1;
                        w_state_next = ST_DONE;
`endif
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_clr        = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    down_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_is_one   (w_is_one)
    );

    assign o_busy  = (r_state == ST_RUN);
    assign o_done  = r_done;
    assign o_count = w_count;

endmodule
`default_nettype wire
